// File: rtl/sram_access_ctrl.sv
// Access sequencer between the MAR/MDR request side and an asynchronous SRAM.
// Sequences reads and writes with programmable wait states, byte lanes and bus turnaround.
module sram_access_ctrl #(
    parameter  int ADDR_W  = 16,
    parameter  int DATA_W  = 16,
    parameter  int RD_WAIT = 2,
    parameter  int WR_WAIT = 2,
    parameter  int TURN    = 1,
    localparam int BE_W    = DATA_W / 8
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Req,
    input  logic              Wr,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [DATA_W-1:0] WData,
    input  logic [BE_W-1:0]   ByteEn,
    output logic              Ready,
    output logic [DATA_W-1:0] RData,
    output logic              RValid,
    output logic              WDone,
    output logic [ADDR_W-1:0] ADDR,
    input  logic [DATA_W-1:0] Data_in,
    output logic [DATA_W-1:0] Data_out,
    output logic              Data_oe,
    output logic              CE,
    output logic              OE,
    output logic              WE,
    output logic [BE_W-1:0]   BE_N
);

    localparam int CNT_MAX = (RD_WAIT > WR_WAIT) ? ((RD_WAIT > TURN) ? RD_WAIT : TURN)
                                                 : ((WR_WAIT > TURN) ? WR_WAIT : TURN);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WR_SETUP,
        S_WR_PULSE,
        S_WR_HOLD,
        S_TURN
    } state_t;

    state_t            state, state_nx;
    logic [CNT_W-1:0]  cnt, cnt_nx;
    logic [BE_W-1:0]   be_q, be_nx;
    logic              accept, rd_done;
    logic              ce_nx, oe_nx, we_nx, data_oe_nx;

    function automatic logic [DATA_W-1:0] lane_mask(input logic [BE_W-1:0] be);
        logic [DATA_W-1:0] m;
        for (int i = 0; i < BE_W; i++) m[i*8 +: 8] = {8{be[i]}};
        return m;
    endfunction

    assign accept  = Req && Ready;
    assign rd_done = (state == S_RD) && (cnt == '0);

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        be_nx    = accept ? ByteEn : be_q;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (Wr) begin
                        state_nx = S_WR_SETUP;
                    end else begin
                        state_nx = S_RD;
                        cnt_nx   = CNT_W'(RD_WAIT - 1);
                    end
                end
            end
            S_RD, S_WR_PULSE, S_TURN: begin
                if (cnt != '0) begin
                    cnt_nx = cnt - CNT_W'(1);
                end else if (state == S_WR_PULSE) begin
                    state_nx = S_WR_HOLD;
                end else if (state == S_RD && TURN > 0) begin
                    state_nx = S_TURN;
                    cnt_nx   = CNT_W'(TURN - 1);
                end else begin
                    state_nx = S_IDLE;
                end
            end
            S_WR_SETUP: begin
                state_nx = S_WR_PULSE;
                cnt_nx   = CNT_W'(WR_WAIT - 1);
            end
            S_WR_HOLD: begin
                if (TURN > 0) begin
                    state_nx = S_TURN;
                    cnt_nx   = CNT_W'(TURN - 1);
                end else begin
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase

        // Strobes are decoded from the next state so the pins come straight from flops.
        ce_nx      = !(state_nx inside {S_RD, S_WR_SETUP, S_WR_PULSE, S_WR_HOLD});
        oe_nx      = (state_nx != S_RD);
        we_nx      = (state_nx != S_WR_PULSE);
        data_oe_nx = (state_nx inside {S_WR_SETUP, S_WR_PULSE, S_WR_HOLD});
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            Ready    <= 1'b1;
            CE       <= 1'b1;
            OE       <= 1'b1;
            WE       <= 1'b1;
            BE_N     <= '1;
            Data_oe  <= 1'b0;
            RValid   <= 1'b0;
            WDone    <= 1'b0;
            RData    <= '0;
            ADDR     <= '0;
            Data_out <= '0;
            be_q     <= '0;
        end else begin
            Ready   <= (state_nx == S_IDLE);
            CE      <= ce_nx;
            OE      <= oe_nx;
            WE      <= we_nx;
            BE_N    <= ce_nx ? '1 : ~be_nx;
            Data_oe <= data_oe_nx;
            RValid  <= rd_done;
            WDone   <= (state == S_WR_HOLD);
            be_q    <= be_nx;
            if (accept) begin
                ADDR     <= Addr;
                Data_out <= WData;
            end
            // Disabled lanes read back as zero rather than whatever floats on the bus.
            if (rd_done) RData <= Data_in & lane_mask(be_q);
        end
    end

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Bench for sram_access_ctrl: two configurations driven with random requests and
// compared every cycle against a transaction-timeline reference model.
module tb_sram_access_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : cfg
        localparam int DW = (g == 0) ? 16 : 32;
        localparam int BW = DW / 8;
        localparam int RW = (g == 0) ? 2 : 1;
        localparam int WW = (g == 0) ? 2 : 3;
        localparam int TW = (g == 0) ? 1 : 0;

        logic          rst, req, wr, ready, rvalid, wdone, data_oe, ce, oe, we;
        logic [15:0]   addr, addr_o;
        logic [DW-1:0] wdata, rdata, din, dout;
        logic [BW-1:0] be, be_n;
        bit            fin = 1'b0;

        sram_access_ctrl #(
            .ADDR_W(16), .DATA_W(DW), .RD_WAIT(RW), .WR_WAIT(WW), .TURN(TW)
        ) dut (
            .Clk(clk), .Reset(rst), .Req(req), .Wr(wr), .Addr(addr), .WData(wdata),
            .ByteEn(be), .Ready(ready), .RData(rdata), .RValid(rvalid), .WDone(wdone),
            .ADDR(addr_o), .Data_in(din), .Data_out(dout), .Data_oe(data_oe),
            .CE(ce), .OE(oe), .WE(we), .BE_N(be_n)
        );

        initial begin
            int            kind;   // 0 none, 1 read, 2 write
            int            d;      // cycles since accepting edge
            int            dir_i;
            bit            rst_done;
            logic [15:0]   addr_m;
            logic [DW-1:0] dout_m, rdata_m, msk;
            logic [BW-1:0] be_m, ben_e;
            logic          rdy_e, ce_e, oe_e, we_e, doe_e, rv_e, wd_e;
            string         pfx;

            pfx = $sformatf("c%0d.", g);
            kind = 0; d = 0; dir_i = 0; rst_done = 1'b0;
            addr_m = '0; dout_m = '0; rdata_m = '0; be_m = '0;
            rst = 1'b1; req = 1'b0; wr = 1'b0; addr = '0; wdata = '0; be = '0; din = '0;

            for (int cyc = 0; cyc < 400; cyc++) begin
                @(negedge clk);
                rdy_e = 1'b1; ce_e = 1'b1; oe_e = 1'b1; we_e = 1'b1;
                doe_e = 1'b0; rv_e = 1'b0; wd_e = 1'b0; ben_e = '1;
                if (kind == 1) begin
                    rdy_e = (d >= RW + TW);
                    if (d < RW) begin ce_e = 1'b0; oe_e = 1'b0; ben_e = ~be_m; end
                    rv_e = (d == RW);
                end else if (kind == 2) begin
                    rdy_e = (d >= WW + 2 + TW);
                    if (d <= WW + 1) begin ce_e = 1'b0; doe_e = 1'b1; ben_e = ~be_m; end
                    we_e = !(d >= 1 && d <= WW);
                    wd_e = (d == WW + 2);
                end
                chk({pfx, "ctl"}, {ready, ce, oe, we, data_oe, rvalid, wdone},
                    {rdy_e, ce_e, oe_e, we_e, doe_e, rv_e, wd_e});
                chk({pfx, "be_n"}, be_n, ben_e);
                chk({pfx, "addr"}, addr_o, addr_m);
                chk({pfx, "dout"}, dout, dout_m);
                chk({pfx, "rdata"}, rdata, rdata_m);
                chk({pfx, "contention"}, data_oe & ~oe, 1'b0);

                // Choose the inputs seen by the next rising edge.
                rst   = (cyc < 2);
                req   = ($urandom_range(0, 3) != 0);
                wr    = $urandom_range(0, 1) != 0;
                addr  = 16'($urandom);
                wdata = DW'({$urandom, $urandom});
                be    = BW'($urandom);
                din   = DW'({$urandom, $urandom});
                if (cyc >= 2 && dir_i < 3) begin
                    req = 1'b1;
                    din = DW'(32'hCAFE_BEEF);
                    case (dir_i)
                        0: begin wr = 1'b0; addr = 16'h1234; be = '1; end
                        1: begin wr = 1'b1; addr = 16'h00FF; wdata = DW'(32'hA55A); be = BW'(1); end
                        default: begin wr = 1'b0; addr = 16'h0042; be = BW'(2); end
                    endcase
                end else if (cyc >= 150 && !rst_done) begin
                    req = 1'b1;
                    wr  = 1'b1;
                    if (kind == 2 && d == 1) begin
                        rst = 1'b1;
                        rst_done = 1'b1;
                    end
                end

                // Reference model advance across the next edge.
                if (rst) begin
                    kind = 0; d = 0;
                    addr_m = '0; dout_m = '0; rdata_m = '0;
                end else if (req && rdy_e) begin
                    kind = wr ? 2 : 1; d = 0;
                    addr_m = addr; dout_m = wdata; be_m = be;
                    if (cyc >= 2 && dir_i < 3) dir_i++;
                end else if (kind != 0 && d < 1000) begin
                    d++;
                end
                if (kind == 1 && d == RW) begin
                    for (int i = 0; i < BW; i++) msk[i*8 +: 8] = {8{be_m[i]}};
                    rdata_m = din & msk;
                end
            end
            fin = 1'b1;
        end
    end

    initial begin
        wait (cfg[0].fin && cfg[1].fin);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
